// File: rtl/ext_mem_dp_loader.sv
// Dual-port CPU memory: port A is the Z80 bus side (write-protectable), port B is a
// valid/ready streaming loader that fills a window of the array with a running checksum.
module ext_mem_dp_loader #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 8,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_ce,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_valid,
    input  logic              lock,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       load_sum
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic              load_fire;
    logic              a_wr;
    logic              a_rd;
    logic              bad_req;
    logic [ADDR_W+1:0] load_end;

    assign load_busy  = (state == ST_LOAD);
    assign load_ready = load_busy;
    // A word offered during a reset cycle must not reach the array.
    assign load_fire  = load_busy & load_valid & ~reset;
    assign a_wr       = a_ce & a_we & ~lock & ~load_busy;
    assign a_rd       = a_ce & ~a_we;

    // Window end computed two bits wider than the address so it cannot wrap.
    assign load_end = {2'b00, load_base} + {1'b0, load_len};
    assign bad_req  = (load_len == '0) || (load_end > (ADDR_W+2)'(DEPTH));

    // No reset on the array: images survive a reset.
    always_ff @(posedge clk) begin
        if (load_fire)
            mem[ptr] <= load_data;
        else if (a_wr)
            mem[a_addr] <= a_din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= a_rd;
            if (a_rd)
                rd_data <= mem[a_addr];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] dout_q;
            logic              valid_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_valid;
                    if (rd_valid)
                        dout_q <= rd_data;
                end
            end

            assign a_dout  = dout_q;
            assign a_valid = valid_q;
        end else begin : g_no_out_reg
            assign a_dout  = rd_data;
            assign a_valid = rd_valid;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            load_sum  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        load_sum  <= '0;
                        if (bad_req) begin
                            load_err <= 1'b1;
                        end else begin
                            ptr   <= load_base;
                            cnt   <= load_len;
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_fire) begin
                        ptr      <= ptr + ADDR_W'(1);
                        cnt      <= cnt - (ADDR_W+1)'(1);
                        load_sum <= load_sum + 16'(load_data);
                        if (cnt == (ADDR_W+1)'(1))
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    load_done <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
